// File: rtl/regfile_wr_arbiter.sv
// Two-requester write-port arbiter for the register file: one holding entry per requester,
// round-robin with same-address ordering, registered write port. REGFILE_ARB_BYPASS_EN adds read forwarding.
module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  input  logic [DW-1:0] rf_rdata0,
  input  logic [DW-1:0] rf_rdata1,
  output logic [DW-1:0] fwd_rdata0,
  output logic [DW-1:0] fwd_rdata1,
  output logic          busy
);

  logic          e0_full_q, e0_full_d;
  logic [AW-1:0] e0_addr_q, e0_addr_d;
  logic [DW-1:0] e0_data_q, e0_data_d;
  logic          e1_full_q, e1_full_d;
  logic [AW-1:0] e1_addr_q, e1_addr_d;
  logic [DW-1:0] e1_data_q, e1_data_d;
  logic          age_q, age_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic grant_any, grant_idx;
  logic load0, load1;

  assign req0_ready = ~e0_full_q;
  assign req1_ready = ~e1_full_q;
  assign load0 = req0_valid & ~e0_full_q & (req0_addr != '0);
  assign load1 = req1_valid & ~e1_full_q & (req1_addr != '0);

  // age_q=1 means entry0 is the older of two pending writes
  always_comb begin
    grant_any = e0_full_q | e1_full_q;
    grant_idx = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    if (e0_full_q && e1_full_q) begin
      if (e0_addr_q == e1_addr_q) begin
        grant_idx = ~age_q;
      end else begin
        grant_idx = rr_ptr_q;
        rr_ptr_d  = ~rr_ptr_q;
      end
    end else begin
      grant_idx = e1_full_q;
    end
  end

  always_comb begin
    e0_full_d = e0_full_q;
    e0_addr_d = e0_addr_q;
    e0_data_d = e0_data_q;
    e1_full_d = e1_full_q;
    e1_addr_d = e1_addr_q;
    e1_data_d = e1_data_q;
    age_d     = age_q;
    wr_en_d   = grant_any;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (grant_any) begin
      if (grant_idx) begin
        wr_addr_d = e1_addr_q;
        wr_data_d = e1_data_q;
        e1_full_d = 1'b0;
      end else begin
        wr_addr_d = e0_addr_q;
        wr_data_d = e0_data_q;
        e0_full_d = 1'b0;
      end
    end

    if (load0) begin
      e0_full_d = 1'b1;
      e0_addr_d = req0_addr;
      e0_data_d = req0_data;
    end
    if (load1) begin
      e1_full_d = 1'b1;
      e1_addr_d = req1_addr;
      e1_data_d = req1_data;
    end

    if (load0 && load1)           age_d = 1'b1;
    else if (load1 && e0_full_q)  age_d = 1'b1;
    else if (load0 && e1_full_q)  age_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_full_q <= 1'b0;
      e0_addr_q <= '0;
      e0_data_q <= '0;
      e1_full_q <= 1'b0;
      e1_addr_q <= '0;
      e1_data_q <= '0;
      age_q     <= 1'b0;
      rr_ptr_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      e0_full_q <= e0_full_d;
      e0_addr_q <= e0_addr_d;
      e0_data_q <= e0_data_d;
      e1_full_q <= e1_full_d;
      e1_addr_q <= e1_addr_d;
      e1_data_q <= e1_data_d;
      age_q     <= age_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = e0_full_q | e1_full_q | wr_en_q;

`ifdef REGFILE_ARB_BYPASS_EN
  always_comb begin
    fwd_rdata0 = rf_rdata0;
    fwd_rdata1 = rf_rdata1;
    if (wr_en_q && (wr_addr_q == rd_addr0) && (rd_addr0 != '0)) fwd_rdata0 = wr_data_q;
    if (wr_en_q && (wr_addr_q == rd_addr1) && (rd_addr1 != '0)) fwd_rdata1 = wr_data_q;
  end
`else
  // read addresses only matter when forwarding is built in
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr0, rd_addr1};
  assign fwd_rdata0 = rf_rdata0;
  assign fwd_rdata1 = rf_rdata1;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a timestamp-based reference model predicts each
// register-file write and the cycle it appears; a monitor pops and compares.
module tb_regfile_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, wr_addr, rd_addr0, rd_addr1;
  logic [DW-1:0] req0_data, req1_data, wr_data, rf_rdata0, rf_rdata1, fwd_rdata0, fwd_rdata1;
  logic          wr_en, busy;

  regfile_wr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .fwd_rdata0(fwd_rdata0), .fwd_rdata1(fwd_rdata1), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // reference model: pending writes tagged with arrival stamps
  bit            m_full[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  int            m_stamp[2];
  int            stamp_ctr = 0;
  bit            m_rr = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] ra, input logic [DW-1:0] rf);
`ifdef REGFILE_ARB_BYPASS_EN
    if (m_we && m_wa == ra && ra != 0) return m_wd;
`endif
    return rf;
  endfunction

  task automatic step(input bit r,
                      input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output bit acc0, output bit acc1);
    int g;
    @(negedge clk);
    chk("ready0", req0_ready, !m_full[0]);
    chk("ready1", req1_ready, !m_full[1]);
    chk("busy", busy, m_full[0] | m_full[1] | m_we);
    chk("wr_en", wr_en, m_we);
    chk("wr_addr", wr_addr, m_wa);
    chk("wr_data", wr_data, m_wd);

    rst = r;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rd_addr0 = ($urandom_range(0, 1) == 1) ? m_wa : AW'($urandom_range(0, 7));
    rd_addr1 = ($urandom_range(0, 1) == 1) ? m_wa : AW'($urandom_range(0, 7));
    rf_rdata0 = $urandom;
    rf_rdata1 = $urandom;
    #1;
    chk("fwd_rdata0", fwd_rdata0, exp_fwd(rd_addr0, rf_rdata0));
    chk("fwd_rdata1", fwd_rdata1, exp_fwd(rd_addr1, rf_rdata1));

    acc0 = !r && v0 && !m_full[0];
    acc1 = !r && v1 && !m_full[1];
    if (r) begin
      m_full[0] = 0; m_full[1] = 0;
      m_rr = 0; m_we = 0; m_wa = '0; m_wd = '0;
      return;
    end
    g = -1;
    if (m_full[0] && m_full[1]) begin
      if (m_addr[0] == m_addr[1]) g = (m_stamp[0] <= m_stamp[1]) ? 0 : 1;
      else begin
        g = m_rr ? 1 : 0;
        m_rr = (g == 0);
      end
    end else if (m_full[0]) g = 0;
    else if (m_full[1]) g = 1;
    m_we = (g >= 0);
    if (g >= 0) begin
      m_wa = m_addr[g];
      m_wd = m_data[g];
      m_full[g] = 0;
      exp_q.push_back('{cyc: cyc + 1, addr: m_wa, data: m_wd});
    end
    if (acc0 && a0 != 0) begin m_full[0] = 1; m_addr[0] = a0; m_data[0] = d0; m_stamp[0] = stamp_ctr; end
    if (acc1 && a1 != 0) begin m_full[1] = 1; m_addr[1] = a1; m_data[1] = d1; m_stamp[1] = stamp_ctr; end
    stamp_ctr++;
  endtask

  task automatic idle(input int n);
    bit x0, x1;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, x0, x1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (wr_en === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_write @cyc %0d: got addr %0h data %0h expected none", cyc, wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("write_cycle", cyc, e.cyc);
            chk("write_addr", wr_addr, e.addr);
            chk("write_data", wr_data, e.data);
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          n_vec++; n_bad++;
          $display("FAIL missing_write @cyc %0d: got wr_en %b expected addr %0h data %0h", cyc, wr_en, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    bit a0, a1;
    bit p0v, p1v;
    logic [AW-1:0] p0a, p1a;
    logic [DW-1:0] p0d, p1d;
    rst = 1'b1;
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    rd_addr0 = '0; rd_addr1 = '0; rf_rdata0 = '0; rf_rdata1 = '0;
    repeat (2) @(posedge clk);
    m_full[0] = 0; m_full[1] = 0;
    started = 1'b1;

    // reset while entry0 holds r5=200: must never be written
    step(0, 1, 5, 200, 0, 0, 0, a0, a1);
    step(1, 0, 0, 0, 0, 0, 0, a0, a1);
    step(1, 0, 0, 0, 0, 0, 0, a0, a1);
    idle(3);
    // single write latency
    step(0, 1, 5, 6, 0, 0, 0, a0, a1);
    idle(3);
    // simultaneous different addresses, twice (round-robin flips)
    step(0, 1, 6, 7, 1, 7, 9, a0, a1);
    idle(3);
    step(0, 1, 6, 7, 1, 7, 9, a0, a1);
    idle(3);
    // same-address ordering
    step(0, 1, 3, 32'hAAAA, 1, 3, 32'h5555, a0, a1);
    idle(3);
    step(0, 0, 0, 0, 1, 3, 32'h5555, a0, a1);
    step(0, 1, 3, 32'hAAAA, 0, 0, 0, a0, a1);
    idle(3);
    // write to r0 is swallowed
    step(0, 1, 0, 32'hFFFF, 0, 0, 0, a0, a1);
    idle(3);

    p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int i = 0; i < 800; i++) begin
      if (!p0v && $urandom_range(0, 2) != 0) begin
        p0v = 1; p0a = AW'($urandom_range(0, 4)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 2) != 0) begin
        p1v = 1; p1a = AW'($urandom_range(0, 4)); p1d = $urandom;
      end
      step($urandom_range(0, 99) == 0, p0v, p0a, p0d, p1v, p1a, p1d, a0, a1);
      if (a0) p0v = 0;
      if (a1) p1v = 0;
    end
    idle(6);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
